data_memory_dp_param: RTL and testbench
=======================================

Name: data_memory_dp_param

Overview:
- Parametrised true dual-port data memory for the multicore matrix-multiply datapath; it replaces the fixed 16x1000 asynchronous-read memory.
- Two independent read/write ports share one clock.
- Reads are synchronous, with configurable latency and a valid strobe.
- Also provides a deterministic write-collision policy, out-of-range address protection, and a hardware clear sweep after reset or on request.

Parameters:
- DATA_W, 16, data word width in bits
- ADDR_W, 16, address port width in bits
- DEPTH, 1000, number of words; legal addresses are 0..DEPTH-1; DEPTH must be ≤ 2^ADDR_W
- RD_LAT, 1, read latency in cycles; legal values are 1 or 2
- CLR_ON_RST, 1, 1 = run a clear sweep after reset; 0 = skip the sweep and leave contents undefined

Ports:
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  synchronous reset, active-high
- clr  in  1  single-cycle request to start a clear sweep
- en_a  in  1  port A access request
- we_a  in  1  port A write enable; only meaningful when en_a=1
- addr_a  in  ADDR_W  port A address
- data_in_a  in  DATA_W  port A write data
- data_out_a  out  DATA_W  port A read data
- valid_a  out  1  data_out_a holds the result of a read
- err_a  out  1  out-of-range flag for port A, aligned with valid_a
- en_b, we_b, addr_b, data_in_b, data_out_b, valid_b, err_b  same as port A, for port B
- coll  out  1  one-cycle pulse: both ports wrote the same address
- busy  out  1  clear sweep in progress; all accesses are ignored

Behaviour:
- Reset values, held while rst=1: data_out_a/b=0, valid_a/b=0, err_a/b=0, coll=0, read pipeline flushed. busy=1 if CLR_ON_RST=1, else 0.
- FSM states: IDLE, CLEAR. Clear address counter width is ADDR_W.
  - rst=1: state goes to CLEAR if CLR_ON_RST=1, else IDLE. Counter is set to 0.
  - CLEAR: writes 0 to ram[cnt] each cycle and increments cnt. After writing DEPTH-1, moves to IDLE on the next edge.
  - CLEAR lasts exactly DEPTH cycles after rst deasserts. busy=1 for the whole state.
  - IDLE with clr=1: moves to CLEAR with cnt=0. Port requests in that same cycle are still serviced.
  - clr during CLEAR is ignored; the sweep does not restart.
  - rst asserted mid-sweep aborts the sweep and restarts it from 0 after release.
- Accesses while busy=1: no write, no valid, no err.
- Write, in IDLE with en_x=1, we_x=1, addr_x<DEPTH: ram[addr_x] takes data_in_x at that edge. A write produces no valid pulse.
- Read, in IDLE with en_x=1, we_x=0:
  - The word is sampled at the edge. data_out_x and valid_x appear RD_LAT cycles after the request edge.
  - valid_x is a one-cycle pulse per request. Back-to-back reads give back-to-back valids (full throughput).
  - data_out_x holds its last value when no read completes.
- Out-of-range (addr_x ≥ DEPTH): a write is dropped and memory is unchanged. A read returns data 0 with valid_x=1 and err_x=1. err_x is also pulsed, aligned to RD_LAT, for an out-of-range write.
- Read-during-write, same or other port, same address: read-first. The read returns the pre-write word.
- Dual write to the same in-range address: port A wins and the port B data is discarded. coll pulses 1 the cycle after the edge.
- Read latency does not depend on collisions. Different-address dual writes both commit.

Test Plan:
- Clear sweep: rst=1 for 3 cycles, then release → busy=1 for exactly 1000 cycles. Reads of addresses 0, 500, 999 afterwards return 0x0000 with valid 1 cycle later (RD_LAT=1).
- Basic write/read: A writes 0x1234 to 10, B writes 0xBEEF to 11; next cycle A reads 11, B reads 10 → data_out_a=0xBEEF, data_out_b=0x1234, both valids pulse once. Repeat with RD_LAT=2 → 2-cycle latency, back-to-back reads give continuous valids.
- Collision: A writes 0xAAAA and B writes 0x5555 to address 42 in the same cycle → coll=1 for one cycle; a later read of 42 returns 0xAAAA.
- Read-first: ram[7]=0x0001; A writes 0x0002 to 7 while B reads 7 in the same cycle → data_out_b=0x0001; the next read of 7 returns 0x0002.
- Out-of-range: A writes 0xFFFF to 1000, then reads 1000 → write dropped, err_a pulses for both; the read gives data_out_a=0 and valid_a=1. ram[999] is unchanged.
- Clear/reset interplay:
  - clr pulse in IDLE after writing 0x00FF to address 3 → busy for 1000 cycles; a read issued during busy gives no valid; address 3 reads 0 afterwards.
  - rst asserted at sweep cycle 400 → sweep restarts and lasts 1000 more cycles.

Source files
------------

// File: rtl/data_memory_dp_param.sv
// True dual-port data memory with 1- or 2-cycle synchronous reads, read-first behaviour and port-A-wins collisions.
// No backpressure: every access is taken, except during a clear sweep (busy), when all accesses are ignored.
module data_memory_dp_param #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH      = 1000,
  parameter int RD_LAT     = 1,
  parameter int CLR_ON_RST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] data_in_a,
  output logic [DATA_W-1:0] data_out_a,
  output logic              valid_a,
  output logic              err_a,
  input  logic              en_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] data_in_b,
  output logic [DATA_W-1:0] data_out_b,
  output logic              valid_b,
  output logic              err_b,
  output logic              coll,
  output logic              busy
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx;
  logic [DATA_W-1:0] ram [0:DEPTH-1];

  logic              act, clr_wr;
  logic              in_a, in_b;
  logic [IDX_W-1:0]  idx_a, idx_b;
  logic              rd_a, rd_b, oor_a, oor_b;
  logic              wr_a, wr_b_raw, wr_b, same;

  logic              s1_vld_a, s1_err_a, s2_vld_a, s2_err_a;
  logic              s1_vld_b, s1_err_b, s2_vld_b, s2_err_b;
  logic [DATA_W-1:0] s1_dat_a, s2_dat_a, s1_dat_b, s2_dat_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= (CLR_ON_RST != 0) ? CLEAR : IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (clr) begin
          state_nx = CLEAR;
          cnt_nx   = '0;
        end
      end
      CLEAR: begin
        cnt_nx = cnt + ADDR_W'(1);
        if (cnt == LAST) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy   = rst ? (CLR_ON_RST != 0) : (state == CLEAR);
  assign act    = !rst && (state == IDLE);
  assign clr_wr = !rst && (state == CLEAR);

  assign in_a  = {1'b0, addr_a} < DEPTH_X;
  assign in_b  = {1'b0, addr_b} < DEPTH_X;
  assign idx_a = addr_a[IDX_W-1:0];
  assign idx_b = addr_b[IDX_W-1:0];

  assign rd_a     = act && en_a && !we_a;
  assign rd_b     = act && en_b && !we_b;
  assign oor_a    = act && en_a && !in_a;
  assign oor_b    = act && en_b && !in_b;
  assign wr_a     = act && en_a && we_a && in_a;
  assign wr_b_raw = act && en_b && we_b && in_b;
  // Same-address dual write: port A keeps the word, port B is dropped.
  assign same     = wr_a && wr_b_raw && (addr_a == addr_b);
  assign wr_b     = wr_b_raw && !same;

  always_ff @(posedge clk) begin
    if (clr_wr) ram[cnt[IDX_W-1:0]] <= '0;
    if (wr_a)   ram[idx_a] <= data_in_a;
    if (wr_b)   ram[idx_b] <= data_in_b;
  end

  // Reads sample ram before this edge's writes land, giving read-first data.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_a <= 1'b0;  s1_err_a <= 1'b0;  s1_dat_a <= '0;
      s2_vld_a <= 1'b0;  s2_err_a <= 1'b0;  s2_dat_a <= '0;
      s1_vld_b <= 1'b0;  s1_err_b <= 1'b0;  s1_dat_b <= '0;
      s2_vld_b <= 1'b0;  s2_err_b <= 1'b0;  s2_dat_b <= '0;
      coll     <= 1'b0;
    end else begin
      s1_vld_a <= rd_a;
      s1_err_a <= oor_a;
      if (rd_a) s1_dat_a <= in_a ? ram[idx_a] : '0;
      s2_vld_a <= s1_vld_a;
      s2_err_a <= s1_err_a;
      if (s1_vld_a) s2_dat_a <= s1_dat_a;

      s1_vld_b <= rd_b;
      s1_err_b <= oor_b;
      if (rd_b) s1_dat_b <= in_b ? ram[idx_b] : '0;
      s2_vld_b <= s1_vld_b;
      s2_err_b <= s1_err_b;
      if (s1_vld_b) s2_dat_b <= s1_dat_b;

      coll <= same;
    end
  end

  assign data_out_a = (RD_LAT == 2) ? s2_dat_a : s1_dat_a;
  assign valid_a    = (RD_LAT == 2) ? s2_vld_a : s1_vld_a;
  assign err_a      = (RD_LAT == 2) ? s2_err_a : s1_err_a;
  assign data_out_b = (RD_LAT == 2) ? s2_dat_b : s1_dat_b;
  assign valid_b    = (RD_LAT == 2) ? s2_vld_b : s1_vld_b;
  assign err_b      = (RD_LAT == 2) ? s2_err_b : s1_err_b;

endmodule

// File: tb/tb_data_memory_dp_param.sv
// Bench for data_memory_dp_param: RD_LAT=1 and RD_LAT=2 instances share stimulus and one reference model.
module tb_data_memory_dp_param;

  localparam int DEPTH = 1000;

  logic        clk, rst, clr;
  logic        en_a, we_a, en_b, we_b;
  logic [15:0] addr_a, addr_b, din_a, din_b;

  logic [15:0] d1_a, d1_b, d2_a, d2_b;
  logic        v1_a, e1_a, v1_b, e1_b, coll1, busy1;
  logic        v2_a, e2_a, v2_b, e2_b, coll2, busy2;

  data_memory_dp_param #(.RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .clr(clr),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_in_a(din_a),
    .data_out_a(d1_a), .valid_a(v1_a), .err_a(e1_a),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_in_b(din_b),
    .data_out_b(d1_b), .valid_b(v1_b), .err_b(e1_b),
    .coll(coll1), .busy(busy1)
  );

  data_memory_dp_param #(.RD_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .clr(clr),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_in_a(din_a),
    .data_out_a(d2_a), .valid_a(v2_a), .err_a(e2_a),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_in_b(din_b),
    .data_out_b(d2_b), .valid_b(v2_b), .err_b(e2_b),
    .coll(coll2), .busy(busy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;
  int cycno  = 0;

  // Reference model: word array plus a count of sweep cycles still to run.
  logic [15:0] mem [0:DEPTH-1];
  int          sweep_left = 0;
  logic        pv_a = 1'b0, pe_a = 1'b0, pv_b = 1'b0, pe_b = 1'b0;
  logic [15:0] pd_a = '0, pd_b = '0;
  logic [15:0] h1_a = '0, h1_b = '0, h2_a = '0, h2_b = '0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h expected %h at %0t", nm, idx, act, exp, $time);
    end
  endtask

  task automatic cyc();
    logic        va, ea, vb, eb, cl, ina, inb;
    logic [15:0] da, db;
    va = 1'b0; ea = 1'b0; vb = 1'b0; eb = 1'b0; cl = 1'b0;
    da = '0; db = '0;
    ina = addr_a < DEPTH;
    inb = addr_b < DEPTH;
    if (rst) begin
      sweep_left = DEPTH;
    end else if (sweep_left > 0) begin
      sweep_left--;
      if (sweep_left == 0)
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end else begin
      if (en_a) begin
        ea = !ina;
        if (!we_a) begin va = 1'b1; da = ina ? mem[addr_a] : 16'h0; end
      end
      if (en_b) begin
        eb = !inb;
        if (!we_b) begin vb = 1'b1; db = inb ? mem[addr_b] : 16'h0; end
      end
      cl = en_a && we_a && ina && en_b && we_b && inb && (addr_a == addr_b);
      if (en_b && we_b && inb) mem[addr_b] = din_b;
      if (en_a && we_a && ina) mem[addr_a] = din_a;
      if (clr) sweep_left = DEPTH;
    end

    @(posedge clk);
    #1;
    cycno++;

    if (rst) begin
      h1_a = '0; h1_b = '0; h2_a = '0; h2_b = '0;
      pv_a = 1'b0; pe_a = 1'b0; pv_b = 1'b0; pe_b = 1'b0;
    end else begin
      if (va) h1_a = da;
      if (vb) h1_b = db;
      if (pv_a) h2_a = pd_a;
      if (pv_b) h2_b = pd_b;
    end

    chk("l1_valid_a", cycno, v1_a, va);
    chk("l1_err_a",   cycno, e1_a, ea);
    chk("l1_data_a",  cycno, d1_a, h1_a);
    chk("l1_valid_b", cycno, v1_b, vb);
    chk("l1_err_b",   cycno, e1_b, eb);
    chk("l1_data_b",  cycno, d1_b, h1_b);
    chk("l1_coll",    cycno, coll1, cl);
    chk("l1_busy",    cycno, busy1, sweep_left > 0);
    chk("l2_valid_a", cycno, v2_a, pv_a);
    chk("l2_err_a",   cycno, e2_a, pe_a);
    chk("l2_data_a",  cycno, d2_a, h2_a);
    chk("l2_valid_b", cycno, v2_b, pv_b);
    chk("l2_err_b",   cycno, e2_b, pe_b);
    chk("l2_data_b",  cycno, d2_b, h2_b);
    chk("l2_coll",    cycno, coll2, cl);
    chk("l2_busy",    cycno, busy2, sweep_left > 0);

    pv_a = va; pe_a = ea; pd_a = da;
    pv_b = vb; pe_b = eb; pd_b = db;
  endtask

  // Counts busy cycles, the current (already busy) cycle included; first step issues whatever is on the ports.
  task automatic count_busy(output int n);
    n = 1;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      en_a = 1'b0; en_b = 1'b0; clr = 1'b0;
      if (!busy1) break;
      n++;
    end
  endtask

  typedef struct {
    logic        a_en, a_we;
    logic [15:0] a_addr, a_din;
    logic        b_en, b_we;
    logic [15:0] b_addr, b_din;
    logic        x_va, x_ea;
    logic [15:0] x_da;
    logic        x_vb, x_eb;
    logic [15:0] x_db;
    logic        x_coll;
  } vec_t;

  vec_t        tbl [14];
  logic        b2b_v1 [6];
  logic        b2b_v2 [6];
  logic [15:0] b2b_d1 [6];
  logic [15:0] b2b_d2 [6];
  logic [15:0] b2b_ad [6];
  int          n;

  initial begin
    //            a_en  a_we  a_addr   a_din     b_en  b_we  b_addr    b_din     va    ea    da        vb    eb    db        coll
    tbl[0]  = '{1'b1, 1'b0, 16'd0,    16'h0000, 1'b1, 1'b0, 16'd500,  16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 16'd999,  16'h0000, 1'b0, 1'b0, 16'd0,    16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 16'd10,   16'h1234, 1'b1, 1'b1, 16'd11,   16'hBEEF, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 16'd11,   16'h0000, 1'b1, 1'b0, 16'd10,   16'h0000, 1'b1, 1'b0, 16'hBEEF, 1'b1, 1'b0, 16'h1234, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 16'd42,   16'hAAAA, 1'b1, 1'b1, 16'd42,   16'h5555, 1'b0, 1'b0, 16'hBEEF, 1'b0, 1'b0, 16'h1234, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 16'd42,   16'h0000, 1'b0, 1'b0, 16'd0,    16'h0000, 1'b1, 1'b0, 16'hAAAA, 1'b0, 1'b0, 16'h1234, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 16'd7,    16'h0001, 1'b0, 1'b0, 16'd0,    16'h0000, 1'b0, 1'b0, 16'hAAAA, 1'b0, 1'b0, 16'h1234, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 16'd7,    16'h0002, 1'b1, 1'b0, 16'd7,    16'h0000, 1'b0, 1'b0, 16'hAAAA, 1'b1, 1'b0, 16'h0001, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 16'd7,    16'h0000, 1'b1, 1'b0, 16'd7,    16'h0000, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0, 16'h0002, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 16'd1000, 16'hFFFF, 1'b0, 1'b0, 16'd0,    16'h0000, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0, 16'h0002, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 16'd1000, 16'h0000, 1'b1, 1'b0, 16'd999,  16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 16'd3,    16'h00FF, 1'b1, 1'b1, 16'hFFFF, 16'h1111, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 16'd3,    16'h0000, 1'b0, 1'b0, 16'd0,    16'h0000, 1'b1, 1'b0, 16'h00FF, 1'b0, 1'b0, 16'h0000, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 16'd0,    16'h0000, 1'b0, 1'b0, 16'd0,    16'h0000, 1'b0, 1'b0, 16'h00FF, 1'b0, 1'b0, 16'h0000, 1'b0};

    // Back-to-back port A reads of 10, 11, 42, 7 then two idle cycles.
    b2b_ad = '{16'd10, 16'd11, 16'd42, 16'd7, 16'd0, 16'd0};
    b2b_v1 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    b2b_d1 = '{16'h1234, 16'hBEEF, 16'hAAAA, 16'h0002, 16'h0002, 16'h0002};
    b2b_v2 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    b2b_d2 = '{16'h00FF, 16'h1234, 16'hBEEF, 16'hAAAA, 16'h0002, 16'h0002};

    rst = 1'b1; clr = 1'b0;
    en_a = 1'b0; we_a = 1'b0; addr_a = '0; din_a = '0;
    en_b = 1'b0; we_b = 1'b0; addr_b = '0; din_b = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'hDEAD;

    repeat (3) cyc();
    rst = 1'b0;
    count_busy(n);
    chk("reset_sweep_len", 0, n, 1000);

    for (int i = 0; i < 14; i++) begin
      en_a = tbl[i].a_en; we_a = tbl[i].a_we; addr_a = tbl[i].a_addr; din_a = tbl[i].a_din;
      en_b = tbl[i].b_en; we_b = tbl[i].b_we; addr_b = tbl[i].b_addr; din_b = tbl[i].b_din;
      cyc();
      chk("tbl_valid_a", i, v1_a, tbl[i].x_va);
      chk("tbl_err_a",   i, e1_a, tbl[i].x_ea);
      chk("tbl_data_a",  i, d1_a, tbl[i].x_da);
      chk("tbl_valid_b", i, v1_b, tbl[i].x_vb);
      chk("tbl_err_b",   i, e1_b, tbl[i].x_eb);
      chk("tbl_data_b",  i, d1_b, tbl[i].x_db);
      chk("tbl_coll",    i, coll1, tbl[i].x_coll);
    end

    en_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      en_a = (i < 4); we_a = 1'b0; addr_a = b2b_ad[i];
      cyc();
      chk("b2b_l1_valid", i, v1_a, b2b_v1[i]);
      chk("b2b_l1_data",  i, d1_a, b2b_d1[i]);
      chk("b2b_l2_valid", i, v2_a, b2b_v2[i]);
      chk("b2b_l2_data",  i, d2_a, b2b_d2[i]);
    end

    // clr in IDLE: the same-cycle read of 3 is still serviced, a read during busy is not.
    clr = 1'b1; en_a = 1'b1; we_a = 1'b0; addr_a = 16'd3;
    cyc();
    chk("clr_same_cycle_valid", 0, v1_a, 1'b1);
    chk("clr_same_cycle_data",  0, d1_a, 16'h00FF);
    chk("clr_busy_start",       0, busy1, 1'b1);
    clr = 1'b0;
    count_busy(n);
    chk("clr_sweep_len", 0, n, 1000);
    en_a = 1'b1; we_a = 1'b0; addr_a = 16'd3;
    cyc();
    chk("clr_read3_valid", 0, v1_a, 1'b1);
    chk("clr_read3_data",  0, d1_a, 16'h0000);
    en_a = 1'b0;

    // rst at sweep cycle 400 restarts a full-length sweep.
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    repeat (399) cyc();
    chk("mid_sweep_busy", 0, busy1, 1'b1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    count_busy(n);
    chk("restart_sweep_len", 0, n, 1000);

    for (int i = 0; i < 3000; i++) begin
      int r;
      en_a = ($urandom_range(0, 3) != 0); we_a = $urandom_range(0, 1) == 1;
      en_b = ($urandom_range(0, 3) != 0); we_b = $urandom_range(0, 1) == 1;
      din_a = 16'($urandom); din_b = 16'($urandom);
      r = $urandom_range(0, 9);
      addr_a = (r < 7) ? 16'($urandom_range(0, 15)) : (r == 7) ? 16'($urandom_range(995, 1005)) :
               (r == 8) ? 16'($urandom_range(0, 999)) : 16'($urandom_range(0, 65535));
      r = $urandom_range(0, 9);
      addr_b = (r < 7) ? 16'($urandom_range(0, 15)) : (r == 7) ? 16'($urandom_range(995, 1005)) :
               (r == 8) ? 16'($urandom_range(0, 999)) : 16'($urandom_range(0, 65535));
      cyc();
    end
    en_a = 1'b0; en_b = 1'b0;
    repeat (3) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
